// File: rtl/operand_loader.sv
// Loadable operand store: packs a serial nibble stream into NUM_WORDS words
// and serves them on a ROM-style combinational read port, signalling completion.
module operand_loader #(
    parameter int NUM_WORDS = 4,
    parameter int NIB_W     = 4,
    localparam int AW       = $clog2(NUM_WORDS),
    localparam int WW       = 8 * NIB_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          in_valid_i,
    input  logic [NIB_W-1:0] in_data_i,
    output logic          in_ready_o,
    input  logic [AW+1:0] rd_addr_i,
    output logic [WW-1:0] rd_data_o,
    output logic          load_done_o,
    output logic          start_o,
    output logic          overflow_o,
    output logic [AW:0]   word_cnt_o
);

    typedef enum logic {FILL, DONE} state_t;

    localparam logic [AW:0] LAST_WORD = (AW+1)'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [2:0]          nib_cnt_q, nib_cnt_d;
    logic [AW:0]         word_cnt_q, word_cnt_d;
    logic [7*NIB_W-1:0]  staging_q, staging_d;
    logic                overflow_q, overflow_d;
    logic                start_q, start_d;
    logic                wr_en;
    logic [WW-1:0]       mem_q [NUM_WORDS];

    // Byte-lane bits of the read address carry no information here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^rd_addr_i[1:0];

    always_comb begin
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        word_cnt_d = word_cnt_q;
        staging_d  = staging_q;
        overflow_d = overflow_q;
        start_d    = 1'b0;
        wr_en      = 1'b0;
        if (clear_i) begin
            state_d    = FILL;
            nib_cnt_d  = '0;
            word_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid_i) begin
                        if (nib_cnt_q == 3'd7) begin
                            wr_en      = 1'b1;
                            nib_cnt_d  = '0;
                            word_cnt_d = word_cnt_q + (AW+1)'(1);
                            if (word_cnt_q == LAST_WORD) begin
                                state_d = DONE;
                                start_d = 1'b1;
                            end
                        end else begin
                            staging_d[int'(nib_cnt_q)*NIB_W +: NIB_W] = in_data_i;
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    if (in_valid_i) overflow_d = 1'b1;
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            nib_cnt_q  <= '0;
            word_cnt_q <= '0;
            staging_q  <= '0;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            nib_cnt_q  <= nib_cnt_d;
            word_cnt_q <= word_cnt_d;
            staging_q  <= staging_d;
            overflow_q <= overflow_d;
            start_q    <= start_d;
            if (wr_en) mem_q[word_cnt_q[AW-1:0]] <= {in_data_i, staging_q};
        end
    end

    assign in_ready_o  = (state_q == FILL) && !clear_i;
    assign load_done_o = (state_q == DONE);
    assign start_o     = start_q;
    assign overflow_o  = overflow_q;
    assign word_cnt_o  = word_cnt_q;
    assign rd_data_o   = mem_q[rd_addr_i[AW+1:2]];

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: queue-based reference model compared every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_operand_loader;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_data = '0;
    logic        in_ready;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        load_done, start, overflow;
    logic [2:0]  word_cnt;

    operand_loader #(.NUM_WORDS(NW), .NIB_W(4)) dut (
        .clk(clk), .rst(rst), .clear_i(clear), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .load_done_o(load_done), .start_o(start),
        .overflow_o(overflow), .word_cnt_o(word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: words held as an array, pending operands as a queue.
    logic [31:0] m_mem [NW];
    logic [3:0]  m_pend [$];
    int          m_wc = 0;
    bit          m_done = 0, m_ovf = 0, m_start = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) m_mem[i] = '0;
            m_pend.delete();
            m_wc = 0; m_done = 0; m_ovf = 0; m_start = 0;
            chk_en = 1'b1;
        end else if (clear) begin
            m_pend.delete();
            m_wc = 0; m_done = 0; m_ovf = 0; m_start = 0;
        end else begin
            m_start = 0;
            if (m_done) begin
                if (in_valid) m_ovf = 1;
            end else if (in_valid) begin
                m_pend.push_back(in_data);
                if (m_pend.size() == 8) begin
                    logic [31:0] w;
                    for (int i = 0; i < 8; i++) w[i*4 +: 4] = m_pend[i];
                    m_mem[m_wc] = w;
                    m_wc++;
                    m_pend.delete();
                    if (m_wc == NW) begin m_done = 1; m_start = 1; end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, !m_done && !clear});
            chk("load_done", {31'd0, load_done}, {31'd0, m_done});
            chk("start",     {31'd0, start},     {31'd0, m_start});
            chk("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            chk("word_cnt",  {29'd0, word_cnt},  32'(m_wc));
            chk("rd_data",   rd_data,            m_mem[rd_addr[3:2]]);
            if (start) start_cnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [3:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic push_word(input logic [3:0] lo, input bit gaps);
        push(lo);
        for (int k = 2; k <= 8; k++) begin
            if (gaps) step($urandom_range(0, 2));
            push(4'(k));
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        rd_addr = a; #1;
        chk(nm, rd_data, exp);
    endtask

    int sc0;

    initial begin
        step(2);
        rst = 1'b0;
        step();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rd(4'd0, 32'h0, "rst_rd0");
        chk("rst_wcnt", {29'd0, word_cnt}, 32'd0);

        // Single word, with read of word 0 during its final transfer.
        for (int k = 1; k <= 7; k++) push(4'(k));
        in_valid = 1'b1; in_data = 4'd8; #2;
        chk("same_cycle_old", rd_data, 32'h0);
        step();
        in_valid = 1'b0;
        chk("same_cycle_new", rd_data, 32'h87654321);
        chk("single_wcnt", {29'd0, word_cnt}, 32'd1);
        chk("single_done", {31'd0, load_done}, 32'd0);

        // Remaining words with random valid gaps.
        for (int n = 1; n < NW; n++) begin
            step($urandom_range(0, 3));
            push_word(4'(n + 1), 1'b1);
        end
        chk("full_done", {31'd0, load_done}, 32'd1);
        step(2);
        chk("start_once", 32'(start_cnt), 32'd1);
        rd(4'd4,  32'h87654322, "rd4");
        rd(4'd8,  32'h87654323, "rd8");
        rd(4'd12, 32'h87654324, "rd12");
        rd(4'd5,  32'h87654322, "rd5");

        // Offers while complete.
        in_valid = 1'b1; in_data = 4'hF;
        step(3);
        in_valid = 1'b0;
        chk("ovf_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        step(2);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        rd(4'd0,  32'h87654321, "ovf_w0");
        rd(4'd12, 32'h87654324, "ovf_w3");

        // Clear, partial word, clear with a transfer offered, then reload word 0.
        clear = 1'b1; step(); clear = 1'b0;
        for (int k = 0; k < 3; k++) push(4'hA);
        clear = 1'b1; in_valid = 1'b1; in_data = 4'hA;
        step();
        clear = 1'b0; in_valid = 1'b0;
        sc0 = start_cnt;
        push_word(4'd1, 1'b0);
        rd(4'd0, 32'h87654321, "clr_w0");
        rd(4'd4, 32'h87654322, "clr_w1_kept");
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_wcnt", {29'd0, word_cnt}, 32'd1);

        // Reset after two words plus a partial.
        push_word(4'h9, 1'b0);
        push(4'h3); push(4'h3);
        rst = 1'b1; step(); rst = 1'b0;
        step();
        for (int i = 0; i < NW; i++) rd(4'(i * 4), 32'h0, "rst_mid_rd");
        chk("rst_mid_wcnt", {29'd0, word_cnt}, 32'd0);
        chk("rst_mid_done", {31'd0, load_done}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_nostart", 32'(start_cnt), 32'(sc0));
        push_word(4'h5, 1'b0);
        rd(4'd0, 32'h87654325, "post_rst_w0");
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
